// File: rtl/systolic_pkg.sv
// Shared sizes, sequencer state encoding and flat-lane helpers for the
// input-stationary systolic array feeder.
`ifndef SYSTOLIC_PKG_SV
`define SYSTOLIC_PKG_SV

// Lane i of a flat vector whose lanes are w bits wide.
`define SYS_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package systolic_pkg;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_WEIGHT_WIDTH = 16;
  localparam int DEF_PSUM_WIDTH   = 32;
  localparam int DEF_ARRAY_HEIGHT = 4;
  localparam int DEF_ARRAY_WIDTH  = 4;
  localparam int DEF_MAX_ROWS     = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    STREAM,
    DRAIN
  } seq_state_t;

endpackage

`endif

// File: rtl/is_row_buffer.sv
// Row store with synchronous write and a registered read port; a write to
// the address being read is forwarded so a just-arrived row is never stale.
module is_row_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/systolic_is_sequencer.sv
// Buffers one input tile plus a run of weight rows, replays them to the
// skewed systolic array as gap-free bursts and captures one psum row per weight row.
module systolic_is_sequencer
  import systolic_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int PSUM_WIDTH   = DEF_PSUM_WIDTH,
  parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
  parameter int MAX_ROWS     = DEF_MAX_ROWS,
  parameter int OUT_LATENCY  = ARRAY_HEIGHT + ARRAY_WIDTH - 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]        cfg_rows,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  in_data,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  w_data,
  output logic                                 input_en,
  output logic                                 process_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  input_in,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  weight_in,
  input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    psum_out,
  output logic                                 out_valid,
  output logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cfg_err
);

  localparam int RW   = $clog2(MAX_ROWS + 1);
  localparam int IC_W = $clog2(ARRAY_HEIGHT + 1);
  localparam int IA_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam int WA_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int T_W  = $clog2(OUT_LATENCY + 1);
  localparam int CW   = (RW > IC_W) ? RW : IC_W;

  seq_state_t      state, state_nxt;
  logic [RW-1:0]   rows;
  logic [IC_W-1:0] in_cnt;
  logic [RW-1:0]   w_cnt;
  logic [CW-1:0]   cnt;
  logic [T_W-1:0]  tmr;
  logic [RW-1:0]   res_idx;
  logic            cfg_ok, in_acc, w_acc, in_full_nxt, w_full_nxt, capture, last_cap;
  logic [IA_W-1:0] in_waddr, in_raddr;
  logic [WA_W-1:0] w_waddr, w_raddr;

  assign busy = (state != IDLE);

  always_comb begin
    cfg_ok      = (cfg_rows != '0) && (cfg_rows <= RW'(MAX_ROWS));
    in_ready    = (state == FILL) && (in_cnt != IC_W'(ARRAY_HEIGHT));
    w_ready     = (state == FILL) && (w_cnt != rows);
    in_acc      = in_valid && in_ready;
    w_acc       = w_valid && w_ready;
    in_full_nxt = ((in_cnt + IC_W'(in_acc)) == IC_W'(ARRAY_HEIGHT));
    w_full_nxt  = ((w_cnt + RW'(w_acc)) == rows);
    // The capture window opens OUT_LATENCY cycles after the first STREAM
    // cycle and may still be open during STREAM for short arrays.
    capture     = ((state == STREAM) || (state == DRAIN)) &&
                  (tmr == T_W'(OUT_LATENCY)) && (res_idx != rows);
    last_cap    = capture && (res_idx == (rows - 1'b1));
    in_waddr    = IA_W'(in_cnt);
    w_waddr     = WA_W'(w_cnt);
    // Read one row ahead so the registered read lands in the replay cycle.
    in_raddr    = (state == LOAD) ? IA_W'(cnt + 1'b1) : '0;
    w_raddr     = (state == STREAM) ? WA_W'(cnt + 1'b1) : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nxt = FILL;
      FILL:    if (in_full_nxt && w_full_nxt) state_nxt = LOAD;
      LOAD:    if (cnt == CW'(ARRAY_HEIGHT - 1)) state_nxt = STREAM;
      STREAM:  if (cnt == CW'(rows - 1'b1)) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rows       <= '0;
      in_cnt     <= '0;
      w_cnt      <= '0;
      cnt        <= '0;
      tmr        <= '0;
      res_idx    <= '0;
      input_en   <= 1'b0;
      process_en <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if ((state == IDLE) && start && cfg_ok) rows <= cfg_rows;

      in_cnt <= (state == FILL) ? in_cnt + IC_W'(in_acc) : '0;
      w_cnt  <= (state == FILL) ? w_cnt + RW'(w_acc) : '0;
      cnt    <= ((state_nxt == state) && ((state == LOAD) || (state == STREAM))) ?
                cnt + 1'b1 : '0;

      // Enables follow the next state so they align with LOAD/STREAM exactly.
      input_en   <= (state_nxt == LOAD);
      process_en <= (state_nxt == STREAM);

      if ((state == STREAM) || (state == DRAIN)) begin
        if (tmr != T_W'(OUT_LATENCY)) tmr <= tmr + 1'b1;
        res_idx <= res_idx + RW'(capture);
      end else begin
        tmr     <= '0;
        res_idx <= '0;
      end

      out_valid <= capture;
      out_last  <= last_cap;
      done      <= last_cap;
      if (capture) out_data <= psum_out;
    end
  end

  is_row_buffer #(
    .WIDTH(ARRAY_HEIGHT * INPUT_WIDTH),
    .DEPTH(ARRAY_HEIGHT)
  ) u_in_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (in_acc),
    .waddr (in_waddr),
    .wdata (in_data),
    .raddr (in_raddr),
    .rdata (input_in)
  );

  is_row_buffer #(
    .WIDTH(ARRAY_WIDTH * WEIGHT_WIDTH),
    .DEPTH(MAX_ROWS)
  ) u_w_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_acc),
    .waddr (w_waddr),
    .wdata (w_data),
    .raddr (w_raddr),
    .rdata (weight_in)
  );

endmodule

// File: tb/tb_systolic_is_sequencer.sv
// Scoreboard bench for systolic_is_sequencer with a behavioural array stub
// that returns each weight row's psum exactly OUT_LATENCY cycles after it is streamed.
module tb_systolic_is_sequencer;

  localparam int LAT = 7;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, w_valid;
  logic [4:0]   cfg_rows;
  logic [63:0]  in_data, w_data, input_in, weight_in;
  logic [127:0] psum_out, out_data;
  logic         in_ready, w_ready, input_en, process_en;
  logic         out_valid, out_last, busy, done, cfg_err;

  always #5 clk = ~clk;

  systolic_is_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .input_en(input_en), .process_en(process_en),
    .input_in(input_in), .weight_in(weight_in), .psum_out(psum_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [127:0] d;
    logic         last;
  } exp_t;

  typedef struct {
    int           due;
    logic [127:0] v;
  } pend_t;

  exp_t         exp_q[$];
  pend_t        pq[$];
  logic [63:0]  in_rows[4];
  logic [63:0]  w_rows[16];
  logic [127:0] exp_rows[16];
  logic [63:0]  ld[4];
  int           ld_i = 0;
  int           total = 0, bad = 0, cyc = 0, cur_rows = 4, done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [63:0] p16(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [127:0] p32(int a, int b, int c, int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Input-stationary array result for one weight row, lane j.
  function automatic logic [127:0] model(logic [63:0] w);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < 4; i++)
        s += int'(ld[i][j*16 +: 16]) * int'(w[(3-i)*16 +: 16]);
      r[j*32 +: 32] = 32'(s);
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Array stub: off-schedule cycles carry a cycle stamp so a mistimed capture is visible.
  always @(negedge clk) begin
    if (!rst_n) begin
      pq.delete();
      ld_i     <= 0;
      psum_out <= '0;
    end else begin
      if (input_en) begin
        ld[ld_i] <= input_in;
        ld_i     <= (ld_i + 1) % 4;
      end
      if (process_en) pq.push_back('{cyc + LAT, model(weight_in)});
      if (pq.size() > 0 && pq[0].due == cyc) begin
        psum_out <= pq[0].v;
        pq.delete(0);
      end else begin
        psum_out <= {4{32'hDEAD0000 + 32'(cyc)}};
      end
    end
  end

  int   ie_len = 0, pe_len = 0, s0 = 0, out_k = 0;
  logic prev_ie = 1'b0, prev_pe = 1'b0;
  exp_t e;

  // Monitor: burst shape, latency and scoreboard comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      ie_len = 0;
      pe_len = 0;
      prev_ie = 1'b0;
      prev_pe = 1'b0;
    end else begin
      if (input_en || process_en) chk("en_exclusive", input_en & process_en, 0);
      if (process_en && !prev_pe) begin
        chk("load_stream_gap", prev_ie, 1);
        s0 = cyc;
        out_k = 0;
      end
      if (input_en) ie_len++;
      else if (prev_ie) begin chk("load_len", ie_len, 4); ie_len = 0; end
      if (process_en) pe_len++;
      else if (prev_pe) begin chk("stream_len", pe_len, cur_rows); pe_len = 0; end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_row", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("row_data", out_data, e.d);
          chk("row_last", out_last, e.last);
          chk("row_latency", cyc - s0, LAT + 1 + out_k);
        end
        out_k++;
      end
      if (done) begin
        done_cnt++;
        chk("done_with_last", out_valid & out_last, 1);
      end
      prev_ie = input_en;
      prev_pe = process_en;
    end
  end

  task automatic send_in(input bit bubbly, input bit late);
    if (late) repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      if (bubbly) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data  = in_rows[i];
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("in_ready_timeout", n, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_w(input int rows, input bit bubbly);
    for (int k = 0; k < rows; k++) begin
      int n;
      n = 0;
      if (bubbly) repeat ($urandom_range(0, 3)) begin w_valid = 1'b0; @(negedge clk); end
      w_valid = 1'b1;
      w_data  = w_rows[k];
      while (!w_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("w_ready_timeout", n, 0);
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  task automatic load_t1();
    for (int i = 0; i < 4; i++) in_rows[i] = p16(4*i+1, 4*i+2, 4*i+3, 4*i+4);
    w_rows[0] = p16(4, 3, 2, 1);
    w_rows[1] = p16(8, 7, 6, 5);
    w_rows[2] = p16(12, 11, 10, 9);
    w_rows[3] = p16(16, 15, 14, 13);
    exp_rows[0] = p32(90, 100, 110, 120);
    exp_rows[1] = p32(202, 228, 254, 280);
    exp_rows[2] = p32(314, 356, 398, 440);
    exp_rows[3] = p32(426, 484, 542, 600);
  endtask

  task automatic run(input int rows, input bit bubbly, input bit wfirst, input bit poke);
    int  n;
    bit  poked;
    cur_rows = rows;
    for (int k = 0; k < rows; k++) exp_q.push_back('{exp_rows[k], (k == rows - 1)});
    start = 1'b1;
    cfg_rows = 5'(rows);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    fork
      send_in(bubbly, wfirst);
      send_w(rows, bubbly);
      if (poke) begin
        start = 1'b1;
        cfg_rows = 5'd9;
        @(negedge clk);
        start = 1'b0;
      end
    join
    n = 0;
    poked = 1'b0;
    while (!done && n < 300) begin
      if (poke && out_valid && !poked) begin
        start = 1'b1;
        cfg_rows = 5'd2;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (poked && !done) chk("busy_in_drain", busy, 1);
    end
    chk("done_seen", done, 1);
    if (poke) begin
      start = 1'b1;
      cfg_rows = 5'd3;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", busy, 0);
    chk("rows_left", exp_q.size(), 0);
  endtask

  task automatic cfg_bad(input int v);
    start = 1'b1;
    cfg_rows = 5'(v);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    @(negedge clk);
    chk("cfg_err_clear", {cfg_err, busy}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    rst_n = 1'b0; start = 1'b0; cfg_rows = '0;
    in_valid = 1'b0; w_valid = 1'b0; in_data = '0; w_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {input_en, process_en, out_valid, out_last, busy, done, cfg_err, in_ready, w_ready}, 0);
    chk("reset_array_data", {input_in, weight_in}, 0);
    chk("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal run, then the same data with bubbly streams, weights first.
    load_t1();
    run(4, 1'b0, 1'b0, 1'b0);
    run(4, 1'b1, 1'b1, 1'b0);

    // Configuration edges.
    cfg_bad(0);
    cfg_bad(17);
    w_rows[0] = p16(0, 0, 0, 2);
    exp_rows[0] = p32(2, 4, 6, 8);
    run(1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic [63:0] w;
      int s, p;
      s = k + 1;
      p = k % 4;
      w = '0;
      w[(3-p)*16 +: 16] = 16'(s);
      w_rows[k] = w;
      exp_rows[k] = p32(s*(4*p+1), s*(4*p+2), s*(4*p+3), s*(4*p+4));
    end
    run(16, 1'b1, 1'b0, 1'b0);

    // Reset two cycles into STREAM.
    load_t1();
    cur_rows = 4;
    start = 1'b1;
    cfg_rows = 5'd4;
    @(negedge clk);
    start = 1'b0;
    fork
      send_in(1'b0, 1'b0);
      send_w(4, 1'b0);
    join
    n = 0;
    while (!process_en && n < 100) begin @(negedge clk); n++; end
    chk("t5_reach_stream", process_en, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_abort_outputs", {input_en, process_en, out_valid, out_last, busy, done, in_ready, w_ready}, 0);
    d0 = done_cnt;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_idle", {busy, out_valid}, 0);
    run(4, 1'b0, 1'b0, 1'b0);

    // Start pulses during FILL, DRAIN and the done cycle are ignored.
    run(4, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
